core_stage_seq: RTL and testbench
=================================

# core_stage_seq

Parametrised single-clock stage sequencer for the multi-cycle core. It generates one-hot stage enables in place of the divided per-stage clocks of the current clock generator. It is generalised to N_STAGES stages and lets any active stage extend its own phase with a busy input, e.g. for memory latency. It adds free-run and single-step modes, a per-stage watchdog, and optional performance counters. The core top instantiates it once and gates every stage's registers with the matching o_stage_en bit.

## Interface
- N_STAGES, 5, number of sequenced stages (2..16); bit 0 = fetch, bit N_STAGES-1 = writeback/retire
- MAX_WAIT, 15, maximum extra cycles any single stage may be held by busy (1..255)
- CNT_W, 32, width of performance counters
- i_clk  in  1  single clock; all state updates on rising edge
- i_reset  in  1  synchronous reset, active-high
- i_run  in  1  level: continuous execution enable
- i_step  in  1  pulse: execute exactly one instruction when idle
- i_stage_busy  in  N_STAGES  bit s high = stage s needs another cycle; sampled only for the active stage
- o_stage_en  out  N_STAGES  one-hot active-stage enable; all-zero when idle or timed out
- o_instr_start  out  1  high in the first cycle of stage 0 of each instruction
- o_retire  out  1  high in the cycle the last stage completes (o_stage_en[N_STAGES-1] & !i_stage_busy[N_STAGES-1])
- o_idle  out  1  high in IDLE state
- o_timeout  out  1  sticky watchdog error
- o_cycle_cnt  out  CNT_W  cycles spent in RUN
- o_retire_cnt  out  CNT_W  instructions retired

## Operation
- States: IDLE, RUN (stage index idx, wait counter wcnt, width clog2(MAX_WAIT+1)), TIMEOUT.
- IDLE: if i_run | i_step, go to RUN with idx=0, wcnt=0. i_run and i_step both high is treated as run.
- RUN, active stage busy low: the stage completes.
  - If idx < N_STAGES-1: idx+1, wcnt=0.
  - If idx == N_STAGES-1: retire. If i_run is high, go to idx=0 with no bubble cycle. Otherwise go to IDLE.
- RUN, active stage busy high:
  - If wcnt < MAX_WAIT: hold idx, wcnt+1.
  - If wcnt == MAX_WAIT: go to TIMEOUT.
  - A stage therefore occupies at most MAX_WAIT+1 cycles.
- TIMEOUT: o_stage_en=0, o_timeout=1. All inputs are ignored; only i_reset exits.
- i_step while in RUN is ignored (not queued). A step instruction ends in IDLE unless i_run is high at retire.
- i_run deasserted mid-instruction: the current instruction runs to retire, then IDLE. The sequencer never aborts mid-instruction.
- Busy bits of inactive stages are don't-care.
- Counters: o_cycle_cnt increments each cycle in RUN; o_retire_cnt increments on o_retire. Both wrap modulo 2^CNT_W.

## Timing
- Reset values: o_stage_en=0, o_instr_start=0, o_retire=0, o_timeout=0, o_idle=1, counters=0, state IDLE.
- Reset takes effect at the next edge, including mid-instruction. The following cycle shows reset values.
- o_stage_en, o_instr_start, o_idle and o_timeout are registered.
- o_retire is combinational on i_stage_busy[N_STAGES-1].
- Start latency: i_run sampled high in IDLE at edge k gives o_stage_en=1 from cycle k+1.
- An unstalled instruction takes N_STAGES cycles. Back-to-back throughput is 1 instruction per N_STAGES cycles.
- Each busy cycle adds exactly one cycle to the instruction.

## Configuration
- STAGE_SEQ_PERF_EN defined: o_cycle_cnt and o_retire_cnt are implemented as specified.
- STAGE_SEQ_PERF_EN undefined: no counter registers are built, and both outputs are tied to 0.
- All other behaviour is identical with or without the macro.

## Test plan
- Free run. N_STAGES=5, no busy, i_run=1 after reset.
  - Required: o_stage_en cycles 00001,00010,00100,01000,10000,00001; o_retire every 5th cycle; o_instr_start on each 00001.
  - After 15 RUN cycles: o_retire_cnt=3, o_cycle_cnt=15.
- Single step. i_run=0, one i_step pulse in IDLE, plus a second i_step pulse during stage 2.
  - Required: exactly one 5-cycle instruction, then o_idle=1, o_retire_cnt=1; the second pulse is ignored.
- Stall. i_run=1, i_stage_busy[3] high for the first 2 cycles of stage 3.
  - Required: o_stage_en=01000 for 3 cycles; the instruction takes 7 cycles; o_retire_cnt +1.
- Watchdog. MAX_WAIT=3, i_stage_busy[2] held high.
  - Required: o_stage_en=00100 for 4 cycles, then 00000 with o_timeout=1.
  - i_run and i_step then have no effect until i_reset.
- Stop and reset.
  - i_run dropped during stage 1 -> the instruction completes through 10000, then o_idle=1.
  - i_reset asserted during stage 2 -> next cycle all outputs at reset values, counters 0.
- Macro off. Scenario 1 rerun without STAGE_SEQ_PERF_EN -> identical o_stage_en/o_retire; o_cycle_cnt=o_retire_cnt=0 throughout.

Source files
------------

// File: rtl/core_stage_seq.sv
// One-hot stage sequencer for the multi-cycle core: IDLE / RUN / TIMEOUT with per-stage busy hold.
// Define STAGE_SEQ_PERF_EN to build the cycle/retire performance counters; otherwise both read 0.
module core_stage_seq #(
    parameter int N_STAGES = 5,
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 32
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_run,
    input  logic                i_step,
    input  logic [N_STAGES-1:0] i_stage_busy,
    output logic [N_STAGES-1:0] o_stage_en,
    output logic                o_instr_start,
    output logic                o_retire,
    output logic                o_idle,
    output logic                o_timeout,
    output logic [CNT_W-1:0]    o_cycle_cnt,
    output logic [CNT_W-1:0]    o_retire_cnt
);
    localparam int WCW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WCW-1:0] MAXW = WCW'(MAX_WAIT);
    localparam logic [N_STAGES-1:0] FIRST = N_STAGES'(1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_TOUT} state_t;

    state_t              r_state, w_state_n;
    logic [N_STAGES-1:0] r_stage_en, w_en_n;
    logic [WCW-1:0]      r_wcnt, w_wcnt_n;
    logic                r_instr_start;
    logic                w_busy, w_last;

    // The one-hot enable doubles as the stage index, so busy selection is a simple mask.
    assign w_busy = |(i_stage_busy & r_stage_en);
    assign w_last = r_stage_en[N_STAGES-1];

    always_comb begin
        w_state_n = r_state;
        w_en_n    = r_stage_en;
        w_wcnt_n  = r_wcnt;
        case (r_state)
            S_IDLE: begin
                if (i_run || i_step) begin
                    w_state_n = S_RUN;
                    w_en_n    = FIRST;
                    w_wcnt_n  = '0;
                end
            end
            S_RUN: begin
                if (!w_busy) begin
                    w_wcnt_n = '0;
                    if (w_last) begin
                        if (i_run) begin
                            w_en_n = FIRST;
                        end else begin
                            w_state_n = S_IDLE;
                            w_en_n    = '0;
                        end
                    end else begin
                        w_en_n = r_stage_en << 1;
                    end
                end else if (r_wcnt == MAXW) begin
                    w_state_n = S_TOUT;
                    w_en_n    = '0;
                end else begin
                    w_wcnt_n = r_wcnt + 1'b1;
                end
            end
            S_TOUT: begin
                w_en_n = '0;
            end
            default: begin
                w_state_n = S_IDLE;
                w_en_n    = '0;
                w_wcnt_n  = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_stage_en    <= '0;
            r_wcnt        <= '0;
            r_instr_start <= 1'b0;
        end else begin
            r_state       <= w_state_n;
            r_stage_en    <= w_en_n;
            r_wcnt        <= w_wcnt_n;
            // A held stage 0 always has a nonzero wait count, so this marks only the first cycle.
            r_instr_start <= (w_state_n == S_RUN) && w_en_n[0] && (w_wcnt_n == '0);
        end
    end

    assign o_stage_en    = r_stage_en;
    assign o_instr_start = r_instr_start;
    assign o_idle        = (r_state == S_IDLE);
    assign o_timeout     = (r_state == S_TOUT);
    assign o_retire      = w_last && !i_stage_busy[N_STAGES-1];

`ifdef STAGE_SEQ_PERF_EN
    logic [CNT_W-1:0] r_cycle_cnt, r_retire_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cycle_cnt  <= '0;
            r_retire_cnt <= '0;
        end else begin
            if (r_state == S_RUN) r_cycle_cnt  <= r_cycle_cnt + 1'b1;
            if (o_retire)         r_retire_cnt <= r_retire_cnt + 1'b1;
        end
    end

    assign o_cycle_cnt  = r_cycle_cnt;
    assign o_retire_cnt = r_retire_cnt;
`else
    assign o_cycle_cnt  = '0;
    assign o_retire_cnt = '0;
`endif

endmodule

// File: tb/tb_core_stage_seq.sv
// Directed bench for core_stage_seq (N_STAGES=5, MAX_WAIT=3); counter expectations follow STAGE_SEQ_PERF_EN.
module tb_core_stage_seq;
    localparam int N = 5;

`ifdef STAGE_SEQ_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst, run, step;
    logic [N-1:0] busy;
    logic [N-1:0] stage_en;
    logic         instr_start, retire, idle, tout;
    logic [31:0]  cyc_cnt, ret_cnt;

    int n_vec = 0;
    int n_err = 0;

    core_stage_seq #(.N_STAGES(N), .MAX_WAIT(3), .CNT_W(32)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_run        (run),
        .i_step       (step),
        .i_stage_busy (busy),
        .o_stage_en   (stage_en),
        .o_instr_start(instr_start),
        .o_retire     (retire),
        .o_idle       (idle),
        .o_timeout    (tout),
        .o_cycle_cnt  (cyc_cnt),
        .o_retire_cnt (ret_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [N-1:0] en, input logic st,
                           input logic ret, input logic idl, input logic to);
        chk({tag, ".en"},    32'(stage_en),    32'(en));
        chk({tag, ".start"}, 32'(instr_start), 32'(st));
        chk({tag, ".retire"}, 32'(retire),     32'(ret));
        chk({tag, ".idle"},  32'(idle),        32'(idl));
        chk({tag, ".tout"},  32'(tout),        32'(to));
    endtask

    task automatic chk_cnt(input string tag, input int cyc, input int ret);
        chk({tag, ".cyc"}, cyc_cnt, PERF ? 32'(cyc) : 32'd0);
        chk({tag, ".ret"}, ret_cnt, PERF ? 32'(ret) : 32'd0);
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; step = 1'b0; busy = '0;
        tick(); tick();
        chk_out("reset", 5'b00000, 0, 0, 1, 0);
        chk_cnt("reset", 0, 0);

        // Free run: 15 cycles of back-to-back instructions
        rst = 1'b0; run = 1'b1;
        tick();
        for (int c = 0; c < 15; c++) begin
            chk_out($sformatf("free%0d", c), 5'(1 << (c % 5)), (c % 5) == 0, (c % 5) == 4, 0, 0);
            tick();
        end
        chk_out("free15", 5'b00001, 1, 0, 0, 0);
        chk_cnt("free15", 15, 3);

        // Drop run during stage 1: instruction completes, then idle
        tick();
        chk_out("stop.s1", 5'b00010, 0, 0, 0, 0);
        run = 1'b0;
        tick(); chk_out("stop.s2", 5'b00100, 0, 0, 0, 0);
        tick(); chk_out("stop.s3", 5'b01000, 0, 0, 0, 0);
        tick(); chk_out("stop.s4", 5'b10000, 0, 1, 0, 0);
        tick(); chk_out("stop.idle", 5'b00000, 0, 0, 1, 0);
        chk_cnt("stop", 20, 4);

        // Single step with a second step pulse during stage 2
        step = 1'b1;
        tick(); step = 1'b0;
        chk_out("step.s0", 5'b00001, 1, 0, 0, 0);
        tick(); chk_out("step.s1", 5'b00010, 0, 0, 0, 0);
        tick(); chk_out("step.s2", 5'b00100, 0, 0, 0, 0);
        step = 1'b1;
        tick(); step = 1'b0;
        chk_out("step.s3", 5'b01000, 0, 0, 0, 0);
        tick(); chk_out("step.s4", 5'b10000, 0, 1, 0, 0);
        tick(); chk_out("step.idle", 5'b00000, 0, 0, 1, 0);
        tick(); chk_out("step.idle2", 5'b00000, 0, 0, 1, 0);
        chk_cnt("step", 25, 5);

        // Stall: stage 3 busy for 2 cycles, an inactive busy bit set alongside
        run = 1'b1;
        tick(); chk_out("stall.s0", 5'b00001, 1, 0, 0, 0);
        tick(); tick();
        chk_out("stall.s2", 5'b00100, 0, 0, 0, 0);
        tick(); busy = 5'b01010;
        chk_out("stall.s3a", 5'b01000, 0, 0, 0, 0);
        tick(); chk_out("stall.s3b", 5'b01000, 0, 0, 0, 0);
        tick(); busy = 5'b00000;
        chk_out("stall.s3c", 5'b01000, 0, 0, 0, 0);
        tick();
        busy = 5'b10000; #1;
        chk_out("stall.s4busy", 5'b10000, 0, 0, 0, 0);
        busy = 5'b00001; run = 1'b0; #1;
        chk_out("stall.s4", 5'b10000, 0, 1, 0, 0);
        tick(); busy = '0;
        chk_out("stall.idle", 5'b00000, 0, 0, 1, 0);
        chk_cnt("stall", 32, 6);

        // Watchdog: stage 2 held busy past MAX_WAIT
        run = 1'b1;
        tick(); tick(); tick();
        busy = 5'b00100;
        for (int c = 0; c < 4; c++) begin
            chk_out($sformatf("wdog%0d", c), 5'b00100, 0, 0, 0, 0);
            tick();
        end
        chk_out("wdog.tout", 5'b00000, 0, 0, 0, 1);
        busy = '0; step = 1'b1;
        tick(); tick(); tick();
        chk_out("wdog.stuck", 5'b00000, 0, 0, 0, 1);
        chk_cnt("wdog", 38, 6);

        // Reset exits timeout
        step = 1'b0; run = 1'b0; rst = 1'b1;
        tick(); rst = 1'b0;
        chk_out("wdog.rst", 5'b00000, 0, 0, 1, 0);
        chk_cnt("wdog.rst", 0, 0);

        // Reset mid-instruction during stage 2
        run = 1'b1;
        tick(); tick(); tick();
        chk_out("mid.s2", 5'b00100, 0, 0, 0, 0);
        rst = 1'b1;
        tick(); rst = 1'b0; run = 1'b0;
        chk_out("mid.rst", 5'b00000, 0, 0, 1, 0);
        chk_cnt("mid.rst", 0, 0);
        tick();
        chk_out("mid.idle", 5'b00000, 0, 0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
